// File: rtl/lsu_mem_bridge.sv
// Bridges the LSU read/write request ports onto a single-outstanding req/gnt/rvalid
// memory bus. A watchdog aborts a hung transaction and reports it with an error ack.
module lsu_mem_bridge #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clk_en,
    input  logic            i_lsu_read,
    input  logic [AW-1:0]   i_r_lsu_addr,
    output logic [DW-1:0]   o_r_lsu_data,
    input  logic            i_lsu_write,
    input  logic [AW-1:0]   i_w_lsu_addr,
    input  logic [DW/8-1:0] i_w_lsu_byte_en,
    input  logic [DW-1:0]   i_w_lsu_data,
    output logic            o_lsu_ack,
    output logic            o_lsu_err,
    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [AW-1:0]   o_mem_addr,
    output logic [DW/8-1:0] o_mem_be,
    output logic [DW-1:0]   o_mem_wdata,
    input  logic            i_mem_gnt,
    input  logic            i_mem_rvalid,
    input  logic [DW-1:0]   i_mem_rdata
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] ACK  = 2'd3;

    localparam int unsigned    CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          expired;

    // cnt holds the number of REQ/WAIT cycles already spent, so the current one is the last allowed.
    assign expired = (TIMEOUT > 0) && (cnt == CNT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            o_r_lsu_data <= '0;
            o_lsu_ack    <= 1'b0;
            o_lsu_err    <= 1'b0;
            o_mem_req    <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_be     <= '0;
            o_mem_wdata  <= '0;
        end else if (i_clk_en) begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (i_lsu_write) begin
                        state       <= REQ;
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= 1'b1;
                        o_mem_addr  <= {i_w_lsu_addr[AW-1:2], 2'b00};
                        o_mem_be    <= i_w_lsu_byte_en;
                        o_mem_wdata <= i_w_lsu_data;
                    end else if (i_lsu_read) begin
                        state       <= REQ;
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= 1'b0;
                        o_mem_addr  <= {i_r_lsu_addr[AW-1:2], 2'b00};
                        o_mem_be    <= '1;
                        o_mem_wdata <= '0;
                    end
                end
                REQ: begin
                    cnt <= cnt + CW'(1);
                    if (expired) begin
                        state        <= ACK;
                        o_mem_req    <= 1'b0;
                        o_lsu_ack    <= 1'b1;
                        o_lsu_err    <= 1'b1;
                        o_r_lsu_data <= '0;
                    end else if (i_mem_gnt) begin
                        state     <= WAIT;
                        o_mem_req <= 1'b0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (expired) begin
                        state        <= ACK;
                        o_lsu_ack    <= 1'b1;
                        o_lsu_err    <= 1'b1;
                        o_r_lsu_data <= '0;
                    end else if (i_mem_rvalid) begin
                        state        <= ACK;
                        o_lsu_ack    <= 1'b1;
                        o_r_lsu_data <= o_mem_we ? '0 : i_mem_rdata;
                    end
                end
                ACK: begin
                    state        <= IDLE;
                    o_lsu_ack    <= 1'b0;
                    o_lsu_err    <= 1'b0;
                    o_r_lsu_data <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
